// File: rtl/c2h_stream_arbiter_pkg.sv
// Shared types, header layout and round-robin selection helper for the
// C2H stream arbiter (package c2h_arb_pkg).
package c2h_arb_pkg;

    // Arbiter state; HDR is only reachable when C2H_SRC_HDR_EN is defined.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        XFER = 2'd2
    } c2h_state_e;

    // Header beat layout: source id in [7:0], sequence number in [23:8].
    localparam int unsigned HDR_ID_LSB  = 0;
    localparam int unsigned HDR_ID_W    = 8;
    localparam int unsigned HDR_SEQ_LSB = 8;
    localparam int unsigned SEQ_W       = 16;

    // Widest supported source count; the selection helper works on this width.
    localparam int unsigned MAX_SRC     = 8;

    // First asserted request at or after ptr, wrapping modulo num.
    // Returns 0 when no request is set; callers qualify with |req.
    function automatic logic [2:0] next_rr(input logic [MAX_SRC-1:0] req,
                                           input logic [2:0]         ptr,
                                           input int unsigned        num);
        logic [2:0]  idx;
        logic        found;
        int unsigned cand;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_SRC; i++) begin
            if (i < num) begin
                cand = (32'(ptr) + i) % num;
                if (!found && req[cand[2:0]]) begin
                    idx   = cand[2:0];
                    found = 1'b1;
                end
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/c2h_stream_arbiter_if.sv
// Handshake bundle for the C2H arbiter: the NUM_SRC producer streams on one
// side and the single XDMA m_axis_c2h stream on the other.
// master: the arbiter's view. slave: the environment (producers + XDMA).
interface c2h_stream_arbiter_if #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 512
);
    logic [NUM_SRC*DATA_W-1:0] s_tdata;
    logic [NUM_SRC-1:0]        s_tvalid;
    logic [NUM_SRC-1:0]        s_tlast;
    logic [NUM_SRC-1:0]        s_tready;

    logic [DATA_W-1:0]         m_axis_c2h_tdata;
    logic [DATA_W/8-1:0]       m_axis_c2h_tkeep;
    logic                      m_axis_c2h_tvalid;
    logic                      m_axis_c2h_tlast;
    logic                      m_axis_c2h_tready;

    modport master (
        input  s_tdata, s_tvalid, s_tlast, m_axis_c2h_tready,
        output s_tready, m_axis_c2h_tdata, m_axis_c2h_tkeep,
               m_axis_c2h_tvalid, m_axis_c2h_tlast
    );

    modport slave (
        output s_tdata, s_tvalid, s_tlast, m_axis_c2h_tready,
        input  s_tready, m_axis_c2h_tdata, m_axis_c2h_tkeep,
               m_axis_c2h_tvalid, m_axis_c2h_tlast
    );
endinterface

// File: rtl/c2h_stream_arbiter_rr_picker.sv
// c2h_rr_picker: combinational rotate-priority encoder. Picks the first
// requesting source at or after rr_ptr_i, wrapping modulo NUM_SRC.
module c2h_rr_picker
    import c2h_arb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [ID_W-1:0]    rr_ptr_i,
    output logic               valid_o,
    output logic [ID_W-1:0]    idx_o
);

    logic [MAX_SRC-1:0] req_pad;
    logic [2:0]         ptr_pad;
    logic [2:0]         pick;

    // Widen to the helper's fixed width and select.
    always_comb begin
        req_pad              = '0;
        req_pad[NUM_SRC-1:0] = req_i;
        ptr_pad              = 3'(rr_ptr_i);
        pick                 = next_rr(req_pad, ptr_pad, NUM_SRC);
        valid_o              = |req_i;
        idx_o                = ID_W'(pick);
    end

endmodule

// File: rtl/c2h_stream_arbiter.sv
// c2h_stream_arbiter: packet-locked round-robin arbiter sharing the XDMA C2H
// AXI-Stream channel between NUM_SRC producers. A grant is taken in IDLE
// (one bubble cycle) and held until the granted source's tlast handshakes.
// Optional macro C2H_SRC_HDR_EN inserts one header beat (id + per-source
// 16-bit sequence number) ahead of every packet.
module c2h_stream_arbiter
    import c2h_arb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 512,
    parameter int ID_W    = 2
) (
    input  logic                    m_axis_c2h_aclk,
    input  logic                    rstn_en,
    c2h_stream_arbiter_if.master    bus,
    output logic [ID_W-1:0]         grant_id,
    output logic                    busy
);

    localparam int KEEP_W = DATA_W / 8;
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_SRC - 1);
    localparam logic [ID_W-1:0] ONE_ID  = ID_W'(1);

    c2h_state_e      state_q, state_d;
    logic [ID_W-1:0] grant_q, grant_d;
    logic [ID_W-1:0] rr_q,    rr_d;

    logic            pick_valid;
    logic [ID_W-1:0] pick_idx;

    logic            xfer_valid;
    logic            xfer_last;
    logic            last_hs;

`ifdef C2H_SRC_HDR_EN
    logic [SEQ_W-1:0] seq_q [NUM_SRC];
`endif

    c2h_rr_picker #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_picker (
        .req_i    (bus.s_tvalid),
        .rr_ptr_i (rr_q),
        .valid_o  (pick_valid),
        .idx_o    (pick_idx)
    );

    // Granted source's handshake signals, used for passthrough and packet end.
    always_comb begin
        xfer_valid = bus.s_tvalid[grant_q];
        xfer_last  = bus.s_tlast[grant_q];
        last_hs    = (state_q == XFER) && xfer_valid && xfer_last
                     && bus.m_axis_c2h_tready;
    end

    // Next-state logic and output mux; outputs are zero outside a grant.
    always_comb begin
        state_d               = state_q;
        grant_d               = grant_q;
        rr_d                  = rr_q;
        bus.s_tready          = '0;
        bus.m_axis_c2h_tdata  = '0;
        bus.m_axis_c2h_tkeep  = '0;
        bus.m_axis_c2h_tvalid = 1'b0;
        bus.m_axis_c2h_tlast  = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
`ifdef C2H_SRC_HDR_EN
                    state_d = HDR;
`else
                    state_d = XFER;
`endif
                end
            end

`ifdef C2H_SRC_HDR_EN
            HDR: begin
                bus.m_axis_c2h_tvalid                          = 1'b1;
                bus.m_axis_c2h_tkeep                           = '1;
                bus.m_axis_c2h_tdata[HDR_ID_LSB +: HDR_ID_W]   = HDR_ID_W'(grant_q);
                bus.m_axis_c2h_tdata[HDR_SEQ_LSB +: SEQ_W]     = seq_q[grant_q];
                if (bus.m_axis_c2h_tready) begin
                    state_d = XFER;
                end
            end
`endif

            XFER: begin
                bus.m_axis_c2h_tvalid   = xfer_valid;
                bus.m_axis_c2h_tlast    = xfer_last;
                bus.m_axis_c2h_tdata    = bus.s_tdata[grant_q*DATA_W +: DATA_W];
                bus.m_axis_c2h_tkeep    = {KEEP_W{xfer_valid}};
                bus.s_tready[grant_q]   = bus.m_axis_c2h_tready;
                if (last_hs) begin
                    state_d = IDLE;
                    rr_d    = (grant_q == LAST_ID) ? '0 : grant_q + ONE_ID;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge m_axis_c2h_aclk or negedge rstn_en) begin
        if (!rstn_en) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
        end
    end

`ifdef C2H_SRC_HDR_EN
    // Per-source packet sequence counters, bumped on each completed packet.
    always_ff @(posedge m_axis_c2h_aclk or negedge rstn_en) begin
        if (!rstn_en) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                seq_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (last_hs && (grant_q == ID_W'(i))) begin
                    seq_q[i] <= seq_q[i] + SEQ_W'(1);
                end
            end
        end
    end
`endif

    // Status outputs.
    always_comb begin
        grant_id = grant_q;
        busy     = (state_q != IDLE);
    end

endmodule

// File: tb/tb_c2h_stream_arbiter.sv
// Directed self-checking bench for c2h_stream_arbiter. A small per-source
// packet generator drives the producer side; every output handshake and
// every cycle's output state is logged, then each test compares the log
// against hand-computed expectations.
module tb_c2h_stream_arbiter;

    localparam int NS = 4;
    localparam int DW = 512;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    c2h_stream_arbiter_if #(.NUM_SRC(NS), .DATA_W(DW)) bus ();

    logic [1:0] grant_id;
    logic       busy;

    c2h_stream_arbiter #(
        .NUM_SRC (NS),
        .DATA_W  (DW),
        .ID_W    (2)
    ) dut (
        .m_axis_c2h_aclk (clk),
        .rstn_en         (rstn),
        .bus             (bus),
        .grant_id        (grant_id),
        .busy            (busy)
    );

    int tests = 0;
    int fails = 0;

    // Producer model: source i sends beats pos..total-1, tlast every plen beats.
    int unsigned pos   [NS];
    int unsigned total [NS];
    int unsigned plen  [NS];

    // Output handshake log.
    logic [DW-1:0] beat_data  [64];
    logic          beat_last  [64];
    logic [1:0]    beat_grant [64];
    int unsigned   beat_cyc   [64];
    int unsigned   nbeats;

    // Per-cycle output log.
    logic [DW-1:0]   cyc_data   [64];
    logic [NS-1:0]   cyc_sready [64];
    logic [DW/8-1:0] cyc_keep   [64];
    int unsigned     ncyc;

    function automatic logic [DW-1:0] beat_val(input int unsigned src, input int unsigned p);
        return DW'((src << 8) | (32'hA + p));
    endfunction

    function automatic logic [DW-1:0] hdr_val(input int unsigned id, input int unsigned seq);
        return DW'((seq << 8) | id);
    endfunction

    task automatic apply();
        for (int i = 0; i < NS; i++) begin
            bus.s_tvalid[i]          = (pos[i] < total[i]);
            bus.s_tlast[i]           = (pos[i] < total[i]) && ((pos[i] % plen[i]) == plen[i] - 1);
            bus.s_tdata[i*DW +: DW]  = beat_val(i, pos[i]);
        end
    endtask

    // One clock: drive at the falling edge, log 1 ns later, advance sources
    // that handshook, and return at the next falling edge.
    task automatic tick();
        logic [NS-1:0] hs;
        apply();
        #1;
        hs = bus.s_tvalid & bus.s_tready;
        if (ncyc < 64) begin
            cyc_data[ncyc]   = bus.m_axis_c2h_tdata;
            cyc_sready[ncyc] = bus.s_tready;
            cyc_keep[ncyc]   = bus.m_axis_c2h_tkeep;
        end
        if (bus.m_axis_c2h_tvalid && bus.m_axis_c2h_tready && nbeats < 64) begin
            beat_data[nbeats]  = bus.m_axis_c2h_tdata;
            beat_last[nbeats]  = bus.m_axis_c2h_tlast;
            beat_grant[nbeats] = grant_id;
            beat_cyc[nbeats]   = ncyc;
            nbeats++;
        end
        ncyc++;
        @(posedge clk);
        for (int i = 0; i < NS; i++) begin
            if (hs[i]) pos[i]++;
        end
        @(negedge clk);
    endtask

    function automatic logic all_done();
        logic d;
        d = 1'b1;
        for (int i = 0; i < NS; i++) begin
            if (pos[i] < total[i]) d = 1'b0;
        end
        return d;
    endfunction

    task automatic clear_log();
        nbeats = 0;
        ncyc   = 0;
    endtask

    task automatic run(input int unsigned budget, input string name);
        int unsigned n;
        n = 0;
        while (!all_done() && n < budget) begin
            tick();
            n++;
        end
        tests++;
        if (!all_done()) begin
            fails++;
            $display("FAIL %s_timeout: sources not drained after %0d cycles, required drained", name, budget);
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        for (int i = 0; i < NS; i++) begin
            pos[i]   = 0;
            total[i] = 0;
            plen[i]  = 1;
        end
        bus.s_tvalid          = '0;
        bus.s_tlast           = '0;
        bus.s_tdata           = '0;
        bus.m_axis_c2h_tready = 1'b1;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        clear_log();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        for (int i = 0; i < NS; i++) begin
            pos[i] = 0; total[i] = 0; plen[i] = 1;
        end
        bus.s_tvalid          = '1;
        bus.s_tlast           = '1;
        bus.s_tdata           = '1;
        bus.m_axis_c2h_tready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        tests++; if (bus.m_axis_c2h_tvalid !== 1'b0) begin fails++; $display("FAIL rst_tvalid: got %b exp 0", bus.m_axis_c2h_tvalid); end
        tests++; if (bus.m_axis_c2h_tlast !== 1'b0) begin fails++; $display("FAIL rst_tlast: got %b exp 0", bus.m_axis_c2h_tlast); end
        tests++; if (bus.m_axis_c2h_tkeep !== '0) begin fails++; $display("FAIL rst_tkeep: got %h exp 0", bus.m_axis_c2h_tkeep); end
        tests++; if (bus.s_tready !== 4'b0000) begin fails++; $display("FAIL rst_s_tready: got %b exp 0000", bus.s_tready); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b exp 0", busy); end
        tests++; if (grant_id !== 2'd0) begin fails++; $display("FAIL rst_grant: got %0d exp 0", grant_id); end
        tests++; if (dut.rr_q !== 2'd0) begin fails++; $display("FAIL rst_rr_ptr: got %0d exp 0", dut.rr_q); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        total[1] = 3; plen[1] = 3;
        tick();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy_after_bubble: got %b exp 1", busy); end
        tests++; if (grant_id !== 2'd1) begin fails++; $display("FAIL single_grant: got %0d exp 1", grant_id); end
        run(10, "single");
        tests++; if (nbeats !== 3) begin fails++; $display("FAIL single_nbeats: got %0d exp 3", nbeats); end
        for (int b = 0; b < 3; b++) begin
            tests++; if (beat_data[b] !== beat_val(1, b)) begin fails++; $display("FAIL single_data%0d: got %0h exp %0h", b, beat_data[b], beat_val(1, b)); end
            tests++; if (beat_last[b] !== (b == 2)) begin fails++; $display("FAIL single_last%0d: got %b exp %b", b, beat_last[b], (b == 2)); end
            tests++; if (beat_cyc[b] !== b + 1) begin fails++; $display("FAIL single_cycle%0d: got %0d exp %0d", b, beat_cyc[b], b + 1); end
        end
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_end: got %b exp 0", busy); end
        tests++; if (dut.rr_q !== 2'd2) begin fails++; $display("FAIL single_rr_ptr: got %0d exp 2", dut.rr_q); end
    endtask

    task automatic test_round_robin();
        int unsigned exp_src [10];
        int unsigned exp_pos [10];
        exp_src = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        exp_pos = '{0, 1, 0, 1, 0, 1, 0, 1, 2, 3};
        do_reset();
        for (int i = 0; i < NS; i++) begin
            total[i] = 2; plen[i] = 2;
        end
        total[0] = 4;
        run(40, "rr");
        tests++; if (nbeats !== 10) begin fails++; $display("FAIL rr_nbeats: got %0d exp 10", nbeats); end
        for (int b = 0; b < 10; b++) begin
            tests++; if (beat_grant[b] !== 2'(exp_src[b])) begin fails++; $display("FAIL rr_grant%0d: got %0d exp %0d", b, beat_grant[b], exp_src[b]); end
            tests++; if (beat_data[b] !== beat_val(exp_src[b], exp_pos[b])) begin fails++; $display("FAIL rr_data%0d: got %0h exp %0h", b, beat_data[b], beat_val(exp_src[b], exp_pos[b])); end
            tests++; if (beat_cyc[b] !== (b / 2) * 3 + 1 + (b % 2)) begin fails++; $display("FAIL rr_cycle%0d: got %0d exp %0d", b, beat_cyc[b], (b / 2) * 3 + 1 + (b % 2)); end
        end
    endtask

    task automatic test_backpressure();
        logic [6:0]  rdy_pat;
        int unsigned exp_off [7];
        rdy_pat = 7'b1110011;
        exp_off = '{0, 0, 1, 1, 1, 2, 3};
        do_reset();
        total[1] = 4; plen[1] = 4;
        for (int t = 0; t < 7; t++) begin
            bus.m_axis_c2h_tready = rdy_pat[t];
            tick();
        end
        bus.m_axis_c2h_tready = 1'b1;
        tests++; if (cyc_keep[0] !== '0) begin fails++; $display("FAIL bp_keep_idle: got %h exp 0", cyc_keep[0]); end
        for (int t = 1; t < 7; t++) begin
            tests++; if (cyc_data[t] !== beat_val(1, exp_off[t])) begin fails++; $display("FAIL bp_data_c%0d: got %0h exp %0h", t, cyc_data[t], beat_val(1, exp_off[t])); end
            tests++; if (cyc_sready[t] !== (rdy_pat[t] ? 4'b0010 : 4'b0000)) begin fails++; $display("FAIL bp_sready_c%0d: got %b exp %b", t, cyc_sready[t], (rdy_pat[t] ? 4'b0010 : 4'b0000)); end
            tests++; if (cyc_keep[t] !== '1) begin fails++; $display("FAIL bp_keep_c%0d: got %h exp all ones", t, cyc_keep[t]); end
        end
        tests++; if (pos[1] !== 4) begin fails++; $display("FAIL bp_consumed: got %0d exp 4", pos[1]); end
        tests++; if (nbeats !== 4) begin fails++; $display("FAIL bp_nbeats: got %0d exp 4", nbeats); end
        for (int b = 0; b < 4; b++) begin
            tests++; if (beat_data[b] !== beat_val(1, b)) begin fails++; $display("FAIL bp_beat%0d: got %0h exp %0h", b, beat_data[b], beat_val(1, b)); end
        end
    endtask

    task automatic test_wrap_skip();
        do_reset();
        total[2] = 1; plen[2] = 1;
        run(10, "wrap_setup");
        tests++; if (dut.rr_q !== 2'd3) begin fails++; $display("FAIL wrap_rr_ptr: got %0d exp 3", dut.rr_q); end
        clear_log();
        total[0] = 1; plen[0] = 1;
        total[2] = 2;
        run(10, "wrap");
        tests++; if (nbeats !== 2) begin fails++; $display("FAIL wrap_nbeats: got %0d exp 2", nbeats); end
        tests++; if (beat_grant[0] !== 2'd0) begin fails++; $display("FAIL wrap_first_grant: got %0d exp 0", beat_grant[0]); end
        tests++; if (beat_data[0] !== beat_val(0, 0)) begin fails++; $display("FAIL wrap_first_data: got %0h exp %0h", beat_data[0], beat_val(0, 0)); end
        tests++; if (beat_last[0] !== 1'b1) begin fails++; $display("FAIL wrap_first_last: got %b exp 1", beat_last[0]); end
        tests++; if (beat_grant[1] !== 2'd2) begin fails++; $display("FAIL wrap_second_grant: got %0d exp 2", beat_grant[1]); end
        tests++; if (beat_data[1] !== beat_val(2, 1)) begin fails++; $display("FAIL wrap_second_data: got %0h exp %0h", beat_data[1], beat_val(2, 1)); end
        tests++; if (beat_cyc[1] !== 3) begin fails++; $display("FAIL wrap_second_cycle: got %0d exp 3", beat_cyc[1]); end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        total[0] = 4; plen[0] = 4;
        repeat (3) tick();
        tests++; if (pos[0] !== 2) begin fails++; $display("FAIL midrst_progress: got %0d exp 2", pos[0]); end
        apply();
        rstn = 1'b0;
        #1;
        tests++; if (bus.m_axis_c2h_tvalid !== 1'b0) begin fails++; $display("FAIL midrst_tvalid: got %b exp 0", bus.m_axis_c2h_tvalid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b exp 0", busy); end
        tests++; if (grant_id !== 2'd0) begin fails++; $display("FAIL midrst_grant: got %0d exp 0", grant_id); end
        tests++; if (bus.s_tready !== 4'b0000) begin fails++; $display("FAIL midrst_sready: got %b exp 0000", bus.s_tready); end
        total[0] = pos[0];
        @(negedge clk);
        rstn = 1'b1;
        clear_log();
        total[2] = 2; plen[2] = 2;
        run(10, "midrst");
        tests++; if (nbeats !== 2) begin fails++; $display("FAIL midrst_nbeats: got %0d exp 2", nbeats); end
        tests++; if (beat_grant[0] !== 2'd2) begin fails++; $display("FAIL midrst_new_grant: got %0d exp 2", beat_grant[0]); end
        tests++; if (beat_data[0] !== beat_val(2, 0)) begin fails++; $display("FAIL midrst_new_data: got %0h exp %0h", beat_data[0], beat_val(2, 0)); end
        tests++; if (beat_cyc[0] !== 1) begin fails++; $display("FAIL midrst_bubble: got %0d exp 1", beat_cyc[0]); end
    endtask

`ifdef C2H_SRC_HDR_EN
    task automatic test_hdr();
        logic [DW-1:0] exp_d [6];
        logic          exp_l [6];
        exp_d = '{hdr_val(3, 0), beat_val(3, 0), beat_val(3, 1),
                  hdr_val(3, 1), beat_val(3, 2), beat_val(3, 3)};
        exp_l = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        do_reset();
        total[3] = 4; plen[3] = 2;
        run(20, "hdr");
        tests++; if (nbeats !== 6) begin fails++; $display("FAIL hdr_nbeats: got %0d exp 6", nbeats); end
        for (int b = 0; b < 6; b++) begin
            tests++; if (beat_data[b] !== exp_d[b]) begin fails++; $display("FAIL hdr_data%0d: got %0h exp %0h", b, beat_data[b], exp_d[b]); end
            tests++; if (beat_last[b] !== exp_l[b]) begin fails++; $display("FAIL hdr_last%0d: got %b exp %b", b, beat_last[b], exp_l[b]); end
        end
        tests++; if (cyc_keep[1] !== '1) begin fails++; $display("FAIL hdr_keep: got %h exp all ones", cyc_keep[1]); end
        tests++; if (cyc_sready[1] !== 4'b0000) begin fails++; $display("FAIL hdr_sready: got %b exp 0000", cyc_sready[1]); end
    endtask
`endif

    initial begin
        nbeats = 0;
        ncyc   = 0;
        test_reset();
`ifdef C2H_SRC_HDR_EN
        test_hdr();
`else
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap_skip();
        test_reset_mid_packet();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard stop so a stuck run still ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached, required completion");
        $fatal(1, "time limit");
    end

endmodule
